vending_customer_engine: RTL and testbench
==========================================

Name: vending_customer_engine

Overview:
- Parametrised successor of the single-product customer block.
- Serves NUM_SLOTS product slots, each with its own price and supply.
- Runs a purchase transaction through a state machine that dispenses one item per ready/valid handshake, accumulates the machine account and returns change.
- Adds restock and collect modes.
- Sits between the front-panel input logic and the dispenser/coin-return actuators.

Parameters:
- NUM_SLOTS, 4, number of product slots (>=2)
- PRICE_W, 4, price width per item
- QTY_W, 4, supply/amount width
- MONEY_W, 7, inserted-money and change width
- ACC_W, 9, machine account width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  request type: 0 none, 1 purchase, 2 restock, 3 collect
- req_valid  in  1  request present
- req_ready  out  1  engine idle, request accepted on valid&ready
- slot_sel  in  $clog2(NUM_SLOTS)  target slot
- amount  in  QTY_W  item count (purchase) or restock quantity
- money  in  MONEY_W  inserted money (purchase)
- price_in  in  PRICE_W  new slot price (restock; 0 = keep)
- disp_valid  out  1  dispense one item from disp_slot
- disp_ready  in  1  dispenser accepted item
- disp_slot  out  $clog2(NUM_SLOTS)  slot being dispensed
- red_light  out  1  last purchase rejected
- change_out  out  MONEY_W  refund/change/collected value, valid with change_valid
- change_valid  out  1  one-cycle strobe
- done  out  1  one-cycle strobe at end of any accepted mode 1-3 request
- machine_acc  out  ACC_W  current account
- supply_out  out  QTY_W  supply of slot_sel (combinational read)

Behaviour:
- Reset (async, rst_n=0):
  - All slot prices and supplies = 0; machine_acc = 0.
  - State IDLE; req_ready = 1.
  - disp_valid, red_light, change_valid, done = 0; change_out = 0; disp_slot = 0.
- States: IDLE, CHECK, DISPENSE, CHANGE, ERROR.
- req_ready = 1 only in IDLE.
- Accepting a mode-0 request is a no-op: no strobes, red_light unchanged.
- Purchase (mode 1):
  - Accept cycle latches slot, amount, money; clears red_light; next state CHECK.
  - CHECK (1 cycle) computes cost = price*amount at PRICE_W+QTY_W bits, with no truncation.
  - Fail if any of: amount==0; amount>supply; cost>money; acc+cost >= 2^ACC_W. Fail -> ERROR, otherwise -> DISPENSE with remaining=amount.
  - ERROR (1 cycle): red_light=1 (held until the next accepted purchase); change_out=money (full refund); change_valid=1; done=1; -> IDLE. No slot or account state changes.
  - DISPENSE: disp_valid=1 and disp_slot=latched slot, held stable until disp_ready.
    - On each handshake: supply[slot] -1, acc += price, remaining -1.
    - The handshake that makes remaining 0 moves to CHANGE.
    - disp_valid drops in CHANGE. Back-to-back handshakes are allowed, one item per cycle.
  - CHANGE (1 cycle): change_out = money-cost; change_valid=1 (also when the change is 0); done=1; -> IDLE.
  - Price is sampled at CHECK. A price change cannot occur mid-transaction because req_ready=0.
- Restock (mode 2), completes in the accept cycle +1:
  - supply[slot] = min(supply+amount, 2^QTY_W-1), saturating.
  - price[slot] = price_in if price_in!=0.
  - done=1; red_light unchanged; no change strobe.
- Collect (mode 3), accept cycle +1:
  - change_out = acc truncated to MONEY_W if ACC_W>MONEY_W. The high part is kept: acc = acc - change_out, else acc = 0.
  - change_valid=1; done=1.
- mode, slot_sel, amount and money are ignored while not in IDLE.
- Reset mid-DISPENSE aborts immediately: no refund. Items already handshaken stay counted.

Decomposition:
- vending_pkg holds:
  - mode encodings MODE_NONE/PURCHASE/RESTOCK/COLLECT;
  - state enum;
  - helper function for the saturating add.
- Sub-module vending_slot_bank holds the price/supply register file:
  - ports for write (restock, saturating), decrement-one strobe and two combinational read ports (slot_sel, latched slot);
  - same clk/rst_n.
- The engine FSM and accumulator stay in vending_customer_engine.

Test Plan:
- Restock slot 1 with amount 11, price_in 2; then purchase slot 1, amount 2, money 20, disp_ready=1 -> two disp_valid handshakes; supply_out 9; machine_acc 4; change_out 16 with change_valid; red_light 0.
- Same slot, purchase amount 2, money 3 -> ERROR; red_light 1; change_out 3; supply 9 and acc 4 unchanged; done pulses.
- Purchase amount 12 with supply 9 -> rejected, full refund. Purchase amount 0 -> rejected.
- Purchase amount 3 with disp_ready held low 5 cycles before each item -> disp_valid and disp_slot stable while stalled; supply decrements only on handshake; req_ready 0 throughout.
- Restock supply 9 by amount 8 -> supply_out 15 (saturated). Restock with price_in 0 -> price unchanged.
- Collect with acc 4 -> change_out 4, acc 0. With acc preloaded to 510 (ACC_W 9), a purchase of cost 4 -> rejected for overflow.
- Assert rst_n low mid-DISPENSE -> all outputs at reset values in the same cycle; IDLE after release.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared encodings and helpers for the multi-slot vending customer engine.
package vending_pkg;

  localparam logic [1:0] MODE_NONE     = 2'd0;
  localparam logic [1:0] MODE_PURCHASE = 2'd1;
  localparam logic [1:0] MODE_RESTOCK  = 2'd2;
  localparam logic [1:0] MODE_COLLECT  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DISPENSE,
    S_CHANGE,
    S_ERROR
  } state_t;

  // a+b clamped to the largest value representable in w bits
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/vending_slot_bank.sv
// Per-slot price/supply registers: saturating restock write, single-item
// decrement, and two combinational read ports.
module vending_slot_bank
  import vending_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int PRICE_W   = 4,
  parameter int QTY_W     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_SLOTS)-1:0] wr_slot,
  input  logic [QTY_W-1:0]             wr_qty,
  input  logic [PRICE_W-1:0]           wr_price,
  input  logic                         dec_en,
  input  logic [$clog2(NUM_SLOTS)-1:0] dec_slot,
  input  logic [$clog2(NUM_SLOTS)-1:0] rd_a_slot,
  output logic [QTY_W-1:0]             rd_a_supply,
  input  logic [$clog2(NUM_SLOTS)-1:0] rd_b_slot,
  output logic [PRICE_W-1:0]           rd_b_price,
  output logic [QTY_W-1:0]             rd_b_supply
);
  localparam int SW = $clog2(NUM_SLOTS);

  logic [NUM_SLOTS-1:0][PRICE_W-1:0] w_price;
  logic [NUM_SLOTS-1:0][QTY_W-1:0]   w_supply;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    logic [PRICE_W-1:0] r_price;
    logic [QTY_W-1:0]   r_supply;

    // restock and dispense never overlap: restock only happens from IDLE
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_price  <= '0;
        r_supply <= '0;
      end else if (wr_en && wr_slot == SW'(g)) begin
        r_supply <= QTY_W'(sat_add(32'(r_supply), 32'(wr_qty), QTY_W));
        if (wr_price != '0) r_price <= wr_price;
      end else if (dec_en && dec_slot == SW'(g)) begin
        r_supply <= r_supply - QTY_W'(1);
      end
    end

    assign w_price[g]  = r_price;
    assign w_supply[g] = r_supply;
  end

  assign rd_a_supply = w_supply[rd_a_slot];
  assign rd_b_price  = w_price[rd_b_slot];
  assign rd_b_supply = w_supply[rd_b_slot];

endmodule

// File: rtl/vending_customer_engine.sv
// Multi-slot vending engine: purchase FSM with per-item dispense handshake,
// machine account, change return, restock and collect requests.
module vending_customer_engine
  import vending_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int PRICE_W   = 4,
  parameter int QTY_W     = 4,
  parameter int MONEY_W   = 7,
  parameter int ACC_W     = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   mode,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [$clog2(NUM_SLOTS)-1:0] slot_sel,
  input  logic [QTY_W-1:0]             amount,
  input  logic [MONEY_W-1:0]           money,
  input  logic [PRICE_W-1:0]           price_in,
  output logic                         disp_valid,
  input  logic                         disp_ready,
  output logic [$clog2(NUM_SLOTS)-1:0] disp_slot,
  output logic                         red_light,
  output logic [MONEY_W-1:0]           change_out,
  output logic                         change_valid,
  output logic                         done,
  output logic [ACC_W-1:0]             machine_acc,
  output logic [QTY_W-1:0]             supply_out
);
  localparam int SW  = $clog2(NUM_SLOTS);
  localparam int CW  = PRICE_W + QTY_W;
  localparam int M1  = (ACC_W > CW) ? ACC_W : CW;
  localparam int XW  = ((M1 > MONEY_W) ? M1 : MONEY_W) + 1;

  state_t r_state, w_next;

  logic [SW-1:0]      r_slot;
  logic [QTY_W-1:0]   r_amount;   // doubles as the remaining-item counter
  logic [MONEY_W-1:0] r_money;
  logic [PRICE_W-1:0] r_price;
  logic [CW-1:0]      r_cost;
  logic [ACC_W-1:0]   r_acc;
  logic [MONEY_W-1:0] r_change;
  logic               r_red, r_cv, r_done;

  logic               w_accept, w_hs, w_fail, w_restock;
  logic [PRICE_W-1:0] w_price_l;
  logic [QTY_W-1:0]   w_supply_l;
  logic [CW-1:0]      w_cost;
  logic [MONEY_W-1:0] w_collect;
  logic [ACC_W-1:0]   w_acc_collect;

  assign req_ready  = (r_state == S_IDLE);
  assign disp_valid = (r_state == S_DISPENSE);
  assign w_accept   = req_valid && req_ready;
  assign w_hs       = disp_valid && disp_ready;
  assign w_restock  = w_accept && (mode == MODE_RESTOCK);

  vending_slot_bank #(
    .NUM_SLOTS (NUM_SLOTS),
    .PRICE_W   (PRICE_W),
    .QTY_W     (QTY_W)
  ) u_bank (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (w_restock),
    .wr_slot     (slot_sel),
    .wr_qty      (amount),
    .wr_price    (price_in),
    .dec_en      (w_hs),
    .dec_slot    (r_slot),
    .rd_a_slot   (slot_sel),
    .rd_a_supply (supply_out),
    .rd_b_slot   (r_slot),
    .rd_b_price  (w_price_l),
    .rd_b_supply (w_supply_l)
  );

  assign w_cost = CW'(w_price_l) * CW'(r_amount);
  assign w_fail = (r_amount == '0) || (r_amount > w_supply_l) ||
                  (XW'(w_cost) > XW'(r_money)) ||
                  (XW'(r_acc) + XW'(w_cost) >= (XW'(1) << ACC_W));

  // collect pays out what fits in the change port and keeps the rest
  if (ACC_W > MONEY_W) begin : g_collect_trunc
    assign w_collect     = r_acc[MONEY_W-1:0];
    assign w_acc_collect = {r_acc[ACC_W-1:MONEY_W], {MONEY_W{1'b0}}};
  end else begin : g_collect_full
    assign w_collect     = MONEY_W'(r_acc);
    assign w_acc_collect = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_accept && mode == MODE_PURCHASE) w_next = S_CHECK;
      S_CHECK:    w_next = w_fail ? S_ERROR : S_DISPENSE;
      S_DISPENSE: if (w_hs && r_amount == QTY_W'(1)) w_next = S_CHANGE;
      default:    w_next = S_IDLE;
    endcase
  end

  // strobes are registered so they line up with the ERROR/CHANGE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot   <= '0;
      r_amount <= '0;
      r_money  <= '0;
      r_price  <= '0;
      r_cost   <= '0;
      r_acc    <= '0;
      r_change <= '0;
      r_red    <= 1'b0;
      r_cv     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_cv   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          case (mode)
            MODE_PURCHASE: begin
              r_slot   <= slot_sel;
              r_amount <= amount;
              r_money  <= money;
              r_red    <= 1'b0;
            end
            MODE_RESTOCK: r_done <= 1'b1;
            MODE_COLLECT: begin
              r_change <= w_collect;
              r_acc    <= w_acc_collect;
              r_cv     <= 1'b1;
              r_done   <= 1'b1;
            end
            default: ;
          endcase
        end
        S_CHECK: begin
          r_price <= w_price_l;
          r_cost  <= w_cost;
          if (w_fail) begin
            r_red    <= 1'b1;
            r_change <= r_money;
            r_cv     <= 1'b1;
            r_done   <= 1'b1;
          end
        end
        S_DISPENSE: if (w_hs) begin
          r_acc    <= r_acc + ACC_W'(r_price);
          r_amount <= r_amount - QTY_W'(1);
          if (r_amount == QTY_W'(1)) begin
            r_change <= r_money - MONEY_W'(r_cost);
            r_cv     <= 1'b1;
            r_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign disp_slot    = r_slot;
  assign red_light    = r_red;
  assign change_out   = r_change;
  assign change_valid = r_cv;
  assign done         = r_done;
  assign machine_acc  = r_acc;

endmodule

// File: tb/tb_vending_customer_engine.sv
// Bench for vending_customer_engine: directed scenario table plus randomized
// requests checked against an array-based behavioural model.
module tb_vending_customer_engine;
  localparam int NS = 4, PW = 4, QW = 4, MW = 7, AW = 9, SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    mode;
  logic          req_valid, req_ready;
  logic [SW-1:0] slot_sel;
  logic [QW-1:0] amount;
  logic [MW-1:0] money;
  logic [PW-1:0] price_in;
  logic          disp_valid, disp_ready;
  logic [SW-1:0] disp_slot;
  logic          red_light, change_valid, done;
  logic [MW-1:0] change_out;
  logic [AW-1:0] machine_acc;
  logic [QW-1:0] supply_out;

  vending_customer_engine #(
    .NUM_SLOTS(NS), .PRICE_W(PW), .QTY_W(QW), .MONEY_W(MW), .ACC_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .req_valid(req_valid), .req_ready(req_ready),
    .slot_sel(slot_sel), .amount(amount), .money(money), .price_in(price_in),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_slot(disp_slot),
    .red_light(red_light), .change_out(change_out), .change_valid(change_valid),
    .done(done), .machine_acc(machine_acc), .supply_out(supply_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // behavioural model
  int m_price[NS], m_sup[NS], m_acc;
  bit m_red;

  function automatic void m_clear();
    for (int i = 0; i < NS; i++) begin m_price[i] = 0; m_sup[i] = 0; end
    m_acc = 0; m_red = 0;
  endfunction

  function automatic void m_purchase(input int s, input int a, input int mo,
                                     output bit ok, output int chg);
    int cost;
    cost = m_price[s] * a;
    ok = (a != 0) && (a <= m_sup[s]) && (cost <= mo) && (m_acc + cost < (1 << AW));
    if (ok) begin m_sup[s] -= a; m_acc += cost; chg = mo - cost; m_red = 0; end
    else    begin chg = mo; m_red = 1; end
  endfunction

  function automatic void m_restock(input int s, input int a, input int p);
    m_sup[s] = (m_sup[s] + a > (1 << QW) - 1) ? (1 << QW) - 1 : m_sup[s] + a;
    if (p != 0) m_price[s] = p;
  endfunction

  function automatic int m_collect();
    int c;
    c = m_acc % (1 << MW);
    m_acc -= c;
    return c;
  endfunction

  task automatic do_req(input int m, input int s, input int a, input int mo, input int p);
    int t;
    t = 0;
    while (!req_ready && t < 100) begin @(posedge clk); #1; t++; end
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL req_ready_wait: got %b, want 1", req_ready);
    end
    mode = 2'(m); slot_sel = SW'(s); amount = QW'(a); money = MW'(mo); price_in = PW'(p);
    req_valid = 1'b1;
    @(posedge clk); #1;
    // busy-time inputs are junk that the engine must ignore
    req_valid = 1'b0;
    mode = 2'($urandom); amount = QW'($urandom); money = MW'($urandom); price_in = PW'($urandom);
  endtask

  // drives the dispenser until done; stall<0 gives random ready
  task automatic run_txn(input int stall, input int sup0, output bit to, output int nd,
                         output logic cv, output logic [MW-1:0] co, output logic rl,
                         output bit stab, output bit rrok);
    int w;
    bit hs, was_v, seen_v;
    to = 1; nd = 0; cv = 0; co = '0; rl = 0; stab = 1; rrok = 1; w = 0; seen_v = 0;
    for (int t = 0; t < 400; t++) begin
      if (done) begin to = 0; cv = change_valid; co = change_out; rl = red_light; break; end
      if (req_ready) rrok = 0;
      if (seen_v && !disp_valid) stab = 0;
      was_v = disp_valid;
      if (disp_valid) begin
        seen_v = 1;
        if (disp_slot !== slot_sel) stab = 0;
        disp_ready = (stall < 0) ? ($urandom_range(0, 1) == 1) : (w >= stall);
      end else disp_ready = 1'b0;
      hs = disp_valid && disp_ready;
      @(posedge clk); #1;
      if (hs) begin nd++; w = 0; end
      else if (was_v) w++;
      if (supply_out !== QW'(sup0 - nd)) stab = 0;
    end
    disp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 0; mode = 0; slot_sel = 0; amount = 0; money = 0;
    price_in = 0; disp_ready = 0;
    m_clear();
    #2;
    n_chk++;
    if ({req_ready, disp_valid, red_light, change_valid, done, disp_slot, change_out, machine_acc, supply_out}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SW'(0), MW'(0), AW'(0), QW'(0)}) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b dv=%b red=%b cv=%b done=%b ds=%0d co=%0d acc=%0d sup=%0d, want 1 0 0 0 0 0 0 0 0",
               req_ready, disp_valid, red_light, change_valid, done, disp_slot, change_out, machine_acc, supply_out);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int s = 0; s < NS; s++) begin
      slot_sel = SW'(s); #1;
      n_chk++;
      if (supply_out !== '0 || req_ready !== 1'b1) begin
        n_fail++; $display("FAIL reset_supply slot %0d: sup=%0d rdy=%b, want 0 1", s, supply_out, req_ready);
      end
    end
    @(posedge clk); #1;
  endtask

  // mode, slot, amt, money, price, stall | nd, change, cv, red, supply(slot), acc
  localparam int NROW = 26;
  localparam int TBL [NROW][12] = '{
    '{2,1,11,0,2,0,   0,0,0,0,11,0},
    '{1,1,2,20,0,0,   2,16,1,0,9,4},
    '{1,1,2,3,0,0,    0,3,1,1,9,4},
    '{1,1,12,127,0,0, 0,127,1,1,9,4},
    '{1,1,0,50,0,0,   0,50,1,1,9,4},
    '{2,1,8,0,0,0,    0,0,0,1,15,4},
    '{2,1,0,0,0,0,    0,0,0,1,15,4},
    '{1,1,1,2,0,0,    1,0,1,0,14,6},
    '{1,1,3,20,0,5,   3,14,1,0,11,12},
    '{3,1,0,0,0,0,    0,12,1,0,11,0},
    '{2,2,15,0,15,0,  0,0,0,0,15,0},
    '{1,2,8,120,0,0,  8,0,1,0,7,120},
    '{2,2,15,0,0,0,   0,0,0,0,15,120},
    '{1,2,8,120,0,0,  8,0,1,0,7,240},
    '{2,2,15,0,0,0,   0,0,0,0,15,240},
    '{1,2,8,120,0,1,  8,0,1,0,7,360},
    '{2,2,15,0,0,0,   0,0,0,0,15,360},
    '{1,2,8,120,0,0,  8,0,1,0,7,480},
    '{1,2,2,30,0,0,   2,0,1,0,5,510},
    '{2,3,5,0,1,0,    0,0,0,0,5,510},
    '{1,3,2,5,0,0,    0,5,1,1,5,510},
    '{1,3,1,5,0,0,    1,4,1,0,4,511},
    '{1,3,1,5,0,0,    0,5,1,1,4,511},
    '{1,1,2,10,0,0,   0,10,1,1,11,511},
    '{3,0,0,0,0,0,    0,127,1,1,0,384},
    '{3,0,0,0,0,0,    0,0,1,1,0,384}
  };

  task automatic test_directed();
    bit to, stab, rrok, ok;
    int nd, chg, sup0;
    logic cv, rl;
    logic [MW-1:0] co;
    for (int i = 0; i < NROW; i++) begin
      sup0 = m_sup[TBL[i][1]];
      if (TBL[i][0] == 1)      m_purchase(TBL[i][1], TBL[i][2], TBL[i][3], ok, chg);
      else if (TBL[i][0] == 2) m_restock(TBL[i][1], TBL[i][2], TBL[i][4]);
      else                     chg = m_collect();
      do_req(TBL[i][0], TBL[i][1], TBL[i][2], TBL[i][3], TBL[i][4]);
      run_txn(TBL[i][5], sup0, to, nd, cv, co, rl, stab, rrok);
      n_chk++;
      if (to) begin n_fail++; $display("FAIL row%0d done_timeout: no done strobe, want one", i); end
      n_chk++;
      if (nd != TBL[i][6]) begin n_fail++; $display("FAIL row%0d items: got %0d, want %0d", i, nd, TBL[i][6]); end
      n_chk++;
      if (cv !== TBL[i][8][0]) begin n_fail++; $display("FAIL row%0d change_valid: got %b, want %0d", i, cv, TBL[i][8]); end
      if (TBL[i][8] == 1) begin
        n_chk++;
        if (co !== MW'(TBL[i][7])) begin n_fail++; $display("FAIL row%0d change_out: got %0d, want %0d", i, co, TBL[i][7]); end
      end
      n_chk++;
      if (rl !== TBL[i][9][0]) begin n_fail++; $display("FAIL row%0d red_light: got %b, want %0d", i, rl, TBL[i][9]); end
      n_chk++;
      if (supply_out !== QW'(TBL[i][10])) begin n_fail++; $display("FAIL row%0d supply: got %0d, want %0d", i, supply_out, TBL[i][10]); end
      n_chk++;
      if (machine_acc !== AW'(TBL[i][11])) begin n_fail++; $display("FAIL row%0d acc: got %0d, want %0d", i, machine_acc, TBL[i][11]); end
      if (TBL[i][0] == 1) begin
        n_chk++;
        if (!stab || !rrok) begin n_fail++; $display("FAIL row%0d dispense_stable: stable=%b busy=%b, want 1 1", i, stab, rrok); end
      end
    end
  endtask

  task automatic test_idle_noop();
    do_req(0, 1, 3, 50, 7);
    n_chk++;
    if ({done, change_valid, req_ready, red_light} !== {1'b0, 1'b0, 1'b1, m_red}) begin
      n_fail++; $display("FAIL mode0_noop: done=%b cv=%b rdy=%b red=%b, want 0 0 1 %b",
                         done, change_valid, req_ready, red_light, m_red);
    end
    @(posedge clk); #1;
    n_chk++;
    if (done !== 1'b0 || machine_acc !== AW'(m_acc)) begin
      n_fail++; $display("FAIL mode0_late: done=%b acc=%0d, want 0 %0d", done, machine_acc, m_acc);
    end
  endtask

  task automatic test_random();
    bit to, stab, rrok, ok;
    int nd, chg, sup0, r, m, s, a, mo, p, st;
    logic cv, rl;
    logic [MW-1:0] co;
    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 9);
      m  = (r == 0) ? 0 : (r <= 5) ? 1 : (r <= 8) ? 2 : 3;
      s  = $urandom_range(0, NS - 1);
      a  = (m == 1) ? $urandom_range(0, 6) : $urandom_range(0, 15);
      mo = $urandom_range(0, 127);
      p  = $urandom_range(0, 15);
      st = $urandom_range(0, 4) - 1;
      if (m == 0) begin
        do_req(0, s, a, mo, p);
        n_chk++;
        if (done !== 1'b0 || change_valid !== 1'b0 || red_light !== m_red) begin
          n_fail++; $display("FAIL rnd%0d noop: done=%b cv=%b red=%b", i, done, change_valid, red_light);
        end
        continue;
      end
      sup0 = m_sup[s];
      ok = 0; chg = 0;
      if (m == 1)      m_purchase(s, a, mo, ok, chg);
      else if (m == 2) m_restock(s, a, p);
      else             chg = m_collect();
      do_req(m, s, a, mo, p);
      run_txn(st, sup0, to, nd, cv, co, rl, stab, rrok);
      n_chk++;
      if (to || cv !== (m != 2) || rl !== m_red) begin
        n_fail++; $display("FAIL rnd%0d status mode %0d: to=%b cv=%b red=%b, want 0 %b %b",
                           i, m, to, cv, rl, (m != 2), m_red);
      end
      n_chk++;
      if (m != 2 && co !== MW'(chg)) begin
        n_fail++; $display("FAIL rnd%0d change mode %0d: got %0d, want %0d", i, m, co, chg);
      end
      n_chk++;
      if (nd != ((m == 1 && ok) ? a : 0) || supply_out !== QW'(m_sup[s]) || machine_acc !== AW'(m_acc)) begin
        n_fail++; $display("FAIL rnd%0d state mode %0d: items=%0d sup=%0d acc=%0d, want %0d %0d %0d",
                           i, m, nd, supply_out, machine_acc, (m == 1 && ok) ? a : 0, m_sup[s], m_acc);
      end
      if (m == 1) begin
        n_chk++;
        if (!stab || !rrok) begin n_fail++; $display("FAIL rnd%0d dispense_stable: %b %b, want 1 1", i, stab, rrok); end
      end
    end
  endtask

  task automatic test_reset_mid_dispense();
    bit to, stab, rrok, ok;
    int nd, chg, acc0;
    logic cv, rl;
    logic [MW-1:0] co;
    chg = m_collect();
    do_req(3, 0, 0, 0, 0);
    run_txn(0, 0, to, nd, cv, co, rl, stab, rrok);
    m_restock(0, 15, 3);
    do_req(2, 0, 15, 0, 3);
    run_txn(0, 0, to, nd, cv, co, rl, stab, rrok);
    acc0 = m_acc;
    do_req(1, 0, 4, 127, 0);
    for (int t = 0; t < 20 && !disp_valid; t++) begin @(posedge clk); #1; end
    n_chk++;
    if (disp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_disp_valid: got %b, want 1", disp_valid); end
    disp_ready = 1'b1;
    @(posedge clk); #1;
    disp_ready = 1'b0;
    n_chk++;
    if (machine_acc !== AW'(acc0 + 3) || supply_out !== QW'(14)) begin
      n_fail++; $display("FAIL mid_first_item: acc=%0d sup=%0d, want %0d 14", machine_acc, supply_out, acc0 + 3);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({req_ready, disp_valid, red_light, change_valid, done, disp_slot, change_out, machine_acc, supply_out}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SW'(0), MW'(0), AW'(0), QW'(0)}) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: rdy=%b dv=%b red=%b cv=%b done=%b co=%0d acc=%0d sup=%0d",
               req_ready, disp_valid, red_light, change_valid, done, change_out, machine_acc, supply_out);
    end
    m_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (req_ready !== 1'b1 || disp_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: rdy=%b dv=%b done=%b, want 1 0 0", req_ready, disp_valid, done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_idle_noop();
    test_random();
    test_reset_mid_dispense();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
